dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Initiator-side controller that drives the DSP48A1 slice top as a multiply-accumulate engine.
- Accepts a burst of operand pairs on a valid/ready stream and issues them to the slice's A/B ports.
- Generates the time-aligned OPMODE per sample (first sample clears the accumulator, later samples add to P), drains the slice pipeline, and returns the final P value on a valid/ready result port.

Parameters:
- LAT, 3, cycles from an operand on dsp_a/dsp_b to the corresponding result visible on dsp_p (A1/B1 reg + M reg + P reg).
- OP_DLY, 2, cycles the per-sample opmode is delayed so it meets its product at the post-adder.
- MAX_LEN, 1024, maximum samples per burst before a forced burst end.
- CNT_W, 16, width of the sample counter (MAX_LEN < 2**CNT_W).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- s_valid, input, 1, operand pair valid.
- s_ready, output, 1, sequencer can accept an operand pair.
- s_a, input, 18, signed multiplicand.
- s_b, input, 18, signed multiplier.
- s_last, input, 1, final pair of the burst.
- m_valid, output, 1, result valid.
- m_ready, input, 1, result consumed.
- m_data, output, 48, accumulated sum (copy of dsp_p).
- m_count, output, CNT_W, samples accumulated in the burst.
- m_trunc, output, 1, burst ended by MAX_LEN, not by s_last.
- dsp_a, output, 18, to slice A.
- dsp_b, output, 18, to slice B.
- dsp_opmode, output, 8, to slice OPMODE.
- dsp_ce, output, 1, drives all slice CE inputs.
- dsp_rst, output, 1, drives all slice RST inputs (active high).
- dsp_p, input, 48, from slice P.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - State IDLE.
  - s_ready=0, m_valid=0, m_data=0, m_count=0, m_trunc=0, dsp_a=0, dsp_b=0, dsp_opmode=0, dsp_ce=1.
  - Opmode delay line cleared to 8'h00.
  - dsp_rst=1 while rst_n=0 and for exactly one clk cycle after rst_n rises.
  - A reset mid-burst discards the burst; no result is produced.
- Handshake: a pair transfers on any clk edge with s_valid&s_ready. m_data, m_count and m_trunc are held stable while m_valid=1 and m_ready=0.
- dsp_a/dsp_b are registered. The edge that accepts a pair loads s_a/s_b; otherwise they load 0.
- Each edge also pushes a tag into an OP_DLY-deep shift register; dsp_opmode is the tag at its output:
  - first sample of a burst: 8'h01 (X=M, Z=0).
  - later samples: 8'h09 (X=M, Z=P).
  - no sample accepted (bubble) during RUN or DRAIN: 8'h08 (X=0, Z=P), so P holds.
  - no sample accepted in IDLE: 8'h00, so P=0.
- FSM:
  - IDLE: s_ready=1. An accepted pair is tagged first, sets m_count=1, and moves to RUN. If that pair also has s_last, or MAX_LEN=1, go straight to DRAIN.
  - RUN: s_ready=1. Each accepted pair increments m_count. An accepted s_last moves to DRAIN. When the accepted pair brings m_count to MAX_LEN without s_last, set m_trunc=1 and move to DRAIN.
  - DRAIN: s_ready=0. A down-counter is loaded with LAT at entry. When it expires, the edge LAT+1 cycles after the last-pair handshake edge captures dsp_p into m_data, sets m_valid=1, and moves to OUT.
  - OUT: s_ready=0. On m_valid&m_ready: m_valid=0, m_count=0, m_trunc=0, go to IDLE. There is no combinational path from m_ready to s_ready.
- Arithmetic: signed 18x18 products accumulate in 48 bits inside the slice. Wrap-around is modular; no saturation and no overflow flag.
- Throughput: one pair per cycle inside a burst. Per-burst overhead is LAT+1 drain cycles plus at least 1 OUT cycle.
- Simultaneous s_last and a MAX_LEN hit on the same pair: s_last wins, m_trunc=0.

Test Plan:
- Reset: rst_n low mid-RUN → all outputs at reset values at once; dsp_rst=1 for one cycle after release; next burst sums correctly.
- Basic burst (back-to-back): a=(2,3,4), b=(5,6,7), last on third → m_valid exactly LAT+1 cycles after last handshake, m_data=56, m_count=3, m_trunc=0.
- Bubbles and signs: a=(-100,7), b=(300,-2) with 3 idle cycles between pairs → m_data=-30014 (48-bit two's complement), m_count=2.
- Backpressure: hold m_ready=0 for 10 cycles → m_valid and m_data stable, s_ready=0; accept, then a new single pair 1×1 → m_data=1, so no stale accumulation.
- Truncation: MAX_LEN=4, six pairs 1×1 with no s_last → m_data=4, m_count=4, m_trunc=1; s_ready=0 from the 4th handshake until the result is taken.
- Boundary: single pair with s_last, a=-131072, b=-131072 → m_data=17179869184, m_count=1.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Streams signed 18x18 operand pairs into a DSP48A1 slice as a MAC, sequences
// the per-sample OPMODE, drains the slice pipeline and returns the burst sum.
module dsp_mac_sequencer #(
    parameter int LAT     = 3,
    parameter int OP_DLY  = 2,
    parameter int MAX_LEN = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [17:0]      s_a,
    input  logic signed [17:0]      s_b,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [47:0]      m_data,
    output logic [CNT_W-1:0]        m_count,
    output logic                    m_trunc,
    output logic signed [17:0]      dsp_a,
    output logic signed [17:0]      dsp_b,
    output logic [7:0]              dsp_opmode,
    output logic                    dsp_ce,
    output logic                    dsp_rst,
    input  logic signed [47:0]      dsp_p
);

    localparam int DLY_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [7:0] OP_IDLE  = 8'h00;  // X=0, Z=0
    localparam logic [7:0] OP_FIRST = 8'h01;  // X=M, Z=0
    localparam logic [7:0] OP_ACC   = 8'h09;  // X=M, Z=P
    localparam logic [7:0] OP_HOLD  = 8'h08;  // X=0, Z=P

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                state_q, state_d;
    logic                  s_ready_q, s_ready_d;
    logic                  m_valid_q, m_valid_d;
    logic signed [47:0]    m_data_q, m_data_d;
    logic [CNT_W-1:0]      m_count_q, m_count_d, cnt_inc;
    logic                  m_trunc_q, m_trunc_d;
    logic signed [17:0]    dsp_a_q, dsp_a_d, dsp_b_q, dsp_b_d;
    logic [7:0]            op_q [OP_DLY];
    logic [7:0]            op_d [OP_DLY];
    logic [DLY_W-1:0]      dly_q, dly_d;
    logic                  dsp_rst_q;
    logic                  accept;
    logic [7:0]            tag;

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_count_d = m_count_q;
        m_trunc_d = m_trunc_q;
        dly_d     = dly_q;
        accept    = s_valid & s_ready_q;
        cnt_inc   = m_count_q + 1'b1;
        tag       = OP_HOLD;
        dsp_a_d   = accept ? s_a : 18'sd0;
        dsp_b_d   = accept ? s_b : 18'sd0;

        case (state_q)
            IDLE: begin
                tag = OP_IDLE;
                if (accept) begin
                    tag       = OP_FIRST;
                    m_count_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    m_trunc_d = 1'b0;
                    state_d   = RUN;
                    if (s_last || MAX_LEN == 1) begin
                        state_d   = DRAIN;
                        dly_d     = DLY_W'(LAT);
                        m_trunc_d = ~s_last;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    tag       = OP_ACC;
                    m_count_d = cnt_inc;
                    if (s_last) begin
                        state_d = DRAIN;
                        dly_d   = DLY_W'(LAT);
                    end else if (cnt_inc == CNT_W'(MAX_LEN)) begin
                        state_d   = DRAIN;
                        dly_d     = DLY_W'(LAT);
                        m_trunc_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The final product reaches P exactly when the counter expires.
                if (dly_q == '0) begin
                    m_data_d  = dsp_p;
                    m_valid_d = 1'b1;
                    state_d   = OUT;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            default: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_count_d = '0;
                    m_trunc_d = 1'b0;
                    state_d   = IDLE;
                end
            end
        endcase

        s_ready_d = (state_d == IDLE) || (state_d == RUN);

        op_d[0] = tag;
        for (int i = 1; i < OP_DLY; i++) begin
            op_d[i] = op_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
            m_trunc_q <= 1'b0;
            dsp_a_q   <= '0;
            dsp_b_q   <= '0;
            dly_q     <= '0;
            dsp_rst_q <= 1'b1;
            for (int i = 0; i < OP_DLY; i++) begin
                op_q[i] <= OP_IDLE;
            end
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
            m_trunc_q <= m_trunc_d;
            dsp_a_q   <= dsp_a_d;
            dsp_b_q   <= dsp_b_d;
            dly_q     <= dly_d;
            dsp_rst_q <= 1'b0;
            op_q      <= op_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_count    = m_count_q;
    assign m_trunc    = m_trunc_q;
    assign dsp_a      = dsp_a_q;
    assign dsp_b      = dsp_b_q;
    assign dsp_opmode = op_q[OP_DLY-1];
    assign dsp_ce     = 1'b1;
    assign dsp_rst    = dsp_rst_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer driving a behavioural DSP48A1 MAC path
// (A1/B1 reg, M reg, registered OPMODE, P reg).
module tb_dsp_mac_sequencer;

    localparam int LAT     = 3;
    localparam int OP_DLY  = 2;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   s_valid, s_ready, s_last;
    logic signed [17:0]     s_a, s_b;
    logic                   m_valid, m_ready;
    logic signed [47:0]     m_data;
    logic [CNT_W-1:0]       m_count;
    logic                   m_trunc;
    logic signed [17:0]     dsp_a, dsp_b;
    logic [7:0]             dsp_opmode;
    logic                   dsp_ce, dsp_rst;
    logic signed [47:0]     dsp_p;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(
        .LAT(LAT), .OP_DLY(OP_DLY), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
        .m_trunc(m_trunc),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
        .dsp_rst(dsp_rst), .dsp_p(dsp_p)
    );

    // Slice model: X mux selects M when OPMODE[1:0]=01, Z mux selects P when OPMODE[3:2]=10
    logic signed [17:0] a1, b1;
    logic signed [35:0] m_r;
    logic [7:0]         opr;
    logic signed [47:0] p_r;

    always @(posedge clk) begin
        if (dsp_rst) begin
            a1 <= '0; b1 <= '0; m_r <= '0; opr <= '0; p_r <= '0;
        end else if (dsp_ce) begin
            a1  <= dsp_a;
            b1  <= dsp_b;
            m_r <= a1 * b1;
            opr <= dsp_opmode;
            p_r <= ((opr[3:2] == 2'b10) ? p_r : 48'sd0)
                 + ((opr[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'sd0);
        end
    end
    assign dsp_p = p_r;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [17:0] a, input logic signed [17:0] b,
                        input logic last);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0;
    endtask

    // Called #1 after the last-pair handshake edge; n-1 is the edge count to m_valid.
    task automatic get_result(input string tag, input logic signed [47:0] ed, input int ec,
                              input logic et, input bit chk_lat, input int hold);
        int n = 0;
        m_ready = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_valid && n < 40);
        chk({tag, "_valid"}, m_valid, 1);
        if (chk_lat) chk({tag, "_lat"}, n - 1, LAT + 1);
        chk({tag, "_data"}, m_data, ed);
        chk({tag, "_count"}, m_count, ec);
        chk({tag, "_trunc"}, m_trunc, et);
        chk({tag, "_sready"}, s_ready, 0);
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {m_valid, s_ready}, 2'b10);
            chk({tag, "_hold_data"}, m_data, ed);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_taken"}, {m_valid, m_trunc, s_ready}, 3'b001);
        chk({tag, "_cnt_clr"}, m_count, 0);
    endtask

    task automatic release_reset(input string tag);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_dsprst_hi"}, {dsp_rst, s_ready}, 2'b10);
        @(negedge clk);
        chk({tag, "_dsprst_lo"}, {dsp_rst, s_ready}, 2'b01);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sready"}, s_ready, 0);
        chk({tag, "_mvalid"}, m_valid, 0);
        chk({tag, "_mdata"}, m_data, 0);
        chk({tag, "_mcount"}, m_count, 0);
        chk({tag, "_mtrunc"}, m_trunc, 0);
        chk({tag, "_dspab"}, {dsp_a, dsp_b}, 0);
        chk({tag, "_opmode"}, dsp_opmode, 0);
        chk({tag, "_ce_rst"}, {dsp_ce, dsp_rst}, 2'b11);
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        release_reset("por");

        // Back-to-back burst: 2*5 + 3*6 + 4*7 = 56
        send(18'sd2, 18'sd5, 1'b0);
        send(18'sd3, 18'sd6, 1'b0);
        send(18'sd4, 18'sd7, 1'b1);
        get_result("basic", 48'sd56, 3, 1'b0, 1'b1, 0);

        // Bubbles and mixed signs, then 10 cycles of backpressure: -30000 - 14
        send(-18'sd100, 18'sd300, 1'b0);
        repeat (3) @(negedge clk);
        send(18'sd7, -18'sd2, 1'b1);
        get_result("bubble", -48'sd30014, 2, 1'b0, 1'b1, 10);

        // A fresh single pair must not inherit the previous sum
        send(18'sd1, 18'sd1, 1'b1);
        get_result("fresh", 48'sd1, 1, 1'b0, 1'b1, 0);

        // Six pairs offered without s_last; only four fit before MAX_LEN closes the burst
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_a = 18'sd1; s_b = 18'sd1; s_last = 1'b0;
            chk("trunc_sready", s_ready, (i < 4) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0; s_a = '0; s_b = '0;
        get_result("trunc", 48'sd4, 4, 1'b1, 1'b0, 0);

        // s_last landing on the MAX_LEN pair is a normal end: 1+2+3+4
        send(18'sd1, 18'sd1, 1'b0);
        send(18'sd2, 18'sd1, 1'b0);
        send(18'sd3, 18'sd1, 1'b0);
        send(18'sd4, 18'sd1, 1'b1);
        get_result("last_at_max", 48'sd10, 4, 1'b0, 1'b1, 0);

        // Reset in the middle of a burst
        send(18'sd5, 18'sd5, 1'b0);
        send(18'sd6, 18'sd6, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        release_reset("midrst");

        // Most negative operands: (-2^17)^2 = 2^34
        send(-18'sd131072, -18'sd131072, 1'b1);
        get_result("boundary", 48'sd17179869184, 1, 1'b0, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
